fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 45 ++++
 rtl/rr_picker.sv | 35 +++
 rtl/fifo_wr_arbiter.sv | 124 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types, default sizes and the round-robin search
//               function for the FIFO write-side arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    localparam int          NREQ_DEF      = 4;
    localparam int          DW_DEF        = 8;
    localparam int          MAX_BURST_DEF = 4;
    // Widest requester vector the search function handles.
    localparam int unsigned RR_MAX        = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Returns the first requesting index found when searching upward from
    // last+1, wrapping modulo nreq. The scan walks the offsets from the
    // farthest to the nearest, so the nearest requester is written last and
    // wins. Returns 0 when nothing requests (callers qualify with |req).
    function automatic int unsigned next_rr(
        input logic [RR_MAX-1:0] req,
        input int unsigned       last,
        input int unsigned       nreq
    );
        int unsigned pick;
        int unsigned j;
        pick = 0;
        for (int unsigned k = RR_MAX; k >= 1; k--) begin
            if (k <= nreq) begin
                j = (last + k) % nreq;
                if (|(req & (RR_MAX'(1) << j))) begin
                    pick = j;
                end
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin picker. Chooses the first active
//               request searching upward from last+1 (wrapping).
// Ports       : req  - per-requester request vector
//               last - index of the previous winner
//               idx  - chosen index (valid when any=1)
//               any  - at least one request is active
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [RR_MAX-1:0] w_req_ext;

    always_comb begin
        w_req_ext            = '0;
        w_req_ext[NREQ-1:0]  = req;
    end

    assign idx = IW'(next_rr(w_req_ext, 32'(last), 32'(NREQ)));
    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin burst arbiter sharing one FIFO write port among
//               NREQ requesters, throttled by the FIFO full/almost-full flags.
// Ports       : wclk, wrst          - write clock, async active-high reset
//               req, req_data       - requester valids and packed data
//               gnt                 - combinational one-hot accept
//               wfull, wfull_a      - FIFO full / almost-full (<=1 free)
//               winc, wdata         - registered FIFO write port
//               owner, busy         - current burst owner / in-burst flag
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ      = NREQ_DEF,
    parameter  int DW        = DW_DEF,
    parameter  int MAX_BURST = MAX_BURST_DEF,
    localparam int OW        = $clog2(NREQ),
    localparam int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic               wclk,
    input  logic               wrst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    input  logic               wfull,
    input  logic               wfull_a,
    output logic               winc,
    output logic [DW-1:0]      wdata,
    output logic [OW-1:0]      owner,
    output logic               busy
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [OW-1:0] r_owner;
    logic [OW-1:0] r_last_owner;
    logic [CW-1:0] r_count;
    logic          r_winc;
    logic [DW-1:0] r_wdata;

    logic [OW-1:0] w_pick_idx;
    logic          w_pick_any;
    logic          w_accept;
    logic          w_last_word;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (OW)
    ) u_picker (
        .req  (req),
        .last (r_last_owner),
        .idx  (w_pick_idx),
        .any  (w_pick_any)
    );

    // Next-state and accept logic.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last_word = 1'b0;
        gnt         = '0;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = BURST;
                end
            end
            BURST: begin
                // With wfull_a the single free slot may already be claimed by
                // the write sitting in the output register, so hold off.
                w_accept    = req[r_owner] && !wfull && !(wfull_a && r_winc);
                w_last_word = w_accept && (r_count == CW'(MAX_BURST - 1));
                if (w_accept) begin
                    gnt[r_owner] = 1'b1;
                end
                if (w_last_word || !req[r_owner]) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_owner      <= '0;
            r_last_owner <= OW'(NREQ - 1);
            r_count      <= '0;
            r_winc       <= 1'b0;
            r_wdata      <= '0;
        end else begin
            r_winc <= w_accept;
            if (w_accept) begin
                r_wdata <= req_data[r_owner*DW +: DW];
                r_count <= r_count + CW'(1);
            end
            if (r_state == IDLE && w_pick_any) begin
                r_owner <= w_pick_idx;
                r_count <= '0;
            end
            if (r_state == BURST && w_state_nxt == IDLE) begin
                r_last_owner <= r_owner;
            end
        end
    end

    assign winc  = r_winc;
    assign wdata = r_wdata;
    assign owner = r_owner;
    assign busy  = (r_state == BURST);

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed self-checking bench for fifo_wr_arbiter (NREQ=4,
//               DW=8, MAX_BURST=4). Requester i presents data {i, word#} and
//               advances its word number whenever it is granted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic               wclk;
    logic               wrst;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic               wfull;
    logic               wfull_a;
    logic               winc;
    logic [DW-1:0]      wdata;
    logic [1:0]         owner;
    logic               busy;

    logic [3:0] cnt [NREQ];
    logic       m_winc;
    logic [7:0] m_wdata;
    int         n_tests;
    int         n_fail;
    int         nwr;

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DW        (DW),
        .MAX_BURST (4)
    ) dut (
        .wclk     (wclk),
        .wrst     (wrst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .wfull    (wfull),
        .wfull_a  (wfull_a),
        .winc     (winc),
        .wdata    (wdata),
        .owner    (owner),
        .busy     (busy)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic update_data();
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*DW +: DW] = {4'(i), cnt[i]};
        end
    endtask

    // One clock: checks grant legality, records the accepted word, advances
    // granted requesters, and checks the registered write against the
    // recorded word (accept -> winc latency of exactly one cycle).
    task automatic cyc();
        logic [3:0] g;
        logic [7:0] d;
        g = gnt;
        d = 8'h00;
        chk("gnt_legal", {31'b0, (g == 4'b0) || (busy && g == (4'b0001 << owner))}, 32'd1);
        for (int i = 0; i < NREQ; i++) begin
            if (g[i]) d = req_data[i*DW +: DW];
        end
        @(posedge wclk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (g[i]) cnt[i] = cnt[i] + 4'd1;
        end
        update_data();
        m_winc = |g;
        if (|g) m_wdata = d;
        chk("winc", {31'b0, winc}, {31'b0, m_winc});
        chk("wdata", {24'b0, wdata}, {24'b0, m_wdata});
    endtask

    task automatic set_in(input logic [3:0] r, input logic f, input logic fa);
        req     = r;
        wfull   = f;
        wfull_a = fa;
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        nwr     = 0;
        m_winc  = 1'b0;
        m_wdata = 8'h00;
        for (int i = 0; i < NREQ; i++) cnt[i] = 4'd0;
        update_data();
        wrst    = 1'b1;
        req     = 4'b1111;
        wfull   = 1'b0;
        wfull_a = 1'b0;

        // Reset held with all requests active.
        repeat (2) @(posedge wclk);
        #1;
        chk("rst_winc",  {31'b0, winc}, 32'd0);
        chk("rst_gnt",   {28'b0, gnt},  32'd0);
        chk("rst_busy",  {31'b0, busy}, 32'd0);
        chk("rst_owner", {30'b0, owner}, 32'd0);
        chk("rst_wdata", {24'b0, wdata}, 32'd0);
        wrst = 1'b0;
        #1;
        chk("idle_gnt",  {28'b0, gnt},  32'd0);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        cyc();

        // All four requesting: owners 0,1,2,3 in 5-cycle slots, 16 writes / 20 cycles.
        for (int j = 1; j <= 20; j++) begin
            int p;
            int b;
            p = (j - 1) % 5;
            b = (j - 1) / 5;
            if (p < 4) begin
                chk("rr_busy",  {31'b0, busy},  32'd1);
                chk("rr_owner", {30'b0, owner}, b % 4);
                chk("rr_gnt",   {28'b0, gnt},   1 << (b % 4));
            end else begin
                chk("rr_bubble_busy", {31'b0, busy}, 32'd0);
                chk("rr_bubble_gnt",  {28'b0, gnt},  32'd0);
            end
            nwr += int'(winc);
            cyc();
        end
        chk("rr_writes", nwr, 32'd16);

        // Owner 0 starts a fifth burst but its request drops: exit, no write.
        set_in(4'b0100, 1'b0, 1'b0);
        chk("drop_busy",  {31'b0, busy},  32'd1);
        chk("drop_owner", {30'b0, owner}, 32'd0);
        chk("drop_gnt",   {28'b0, gnt},   32'd0);
        cyc();
        chk("solo_idle_busy", {31'b0, busy}, 32'd0);
        chk("solo_idle_gnt",  {28'b0, gnt},  32'd0);
        cyc();

        // Only requester 2: four back-to-back grants, bubble, re-grant.
        for (int j = 0; j < 4; j++) begin
            chk("solo_owner", {30'b0, owner}, 32'd2);
            chk("solo_gnt",   {28'b0, gnt},   32'b0100);
            cyc();
        end
        chk("solo_bubble_busy", {31'b0, busy},  32'd0);
        chk("solo_last_wdata",  {24'b0, wdata}, 32'h27);
        cyc();
        chk("solo_regrant_owner", {30'b0, owner}, 32'd2);
        chk("solo_regrant_gnt",   {28'b0, gnt},   32'b0100);
        set_in(4'b0000, 1'b0, 1'b0);
        cyc();

        // Owner 1: two words, stall on wfull for 5 cycles, then the last two.
        set_in(4'b0010, 1'b0, 1'b0);
        chk("stall_idle_gnt", {28'b0, gnt}, 32'd0);
        cyc();
        chk("stall_owner", {30'b0, owner}, 32'd1);
        chk("stall_w0",    {28'b0, gnt},   32'b0010);
        cyc();
        chk("stall_w1",    {28'b0, gnt},   32'b0010);
        cyc();
        set_in(4'b0010, 1'b1, 1'b0);
        for (int j = 0; j < 5; j++) begin
            chk("stall_gnt",  {28'b0, gnt},  32'd0);
            chk("stall_busy", {31'b0, busy}, 32'd1);
            cyc();
        end
        chk("stall_winc_low", {31'b0, winc}, 32'd0);
        set_in(4'b0010, 1'b0, 1'b0);
        chk("stall_w2", {28'b0, gnt}, 32'b0010);
        cyc();
        chk("stall_w3", {28'b0, gnt}, 32'b0010);
        cyc();
        chk("stall_end_busy", {31'b0, busy}, 32'd0);
        chk("stall_end_winc", {31'b0, winc}, 32'd1);

        // Almost full: requester 3 accepts every other cycle.
        set_in(4'b1000, 1'b0, 1'b1);
        cyc();
        chk("afull_owner", {30'b0, owner}, 32'd3);
        for (int k = 0; k < 5; k++) begin
            chk("afull_winc", {31'b0, winc}, k % 2);
            chk("afull_gnt",  {28'b0, gnt},  (k % 2 == 0) ? 32'b1000 : 32'd0);
            cyc();
        end
        set_in(4'b1000, 1'b1, 1'b1);
        chk("full_gnt", {28'b0, gnt}, 32'd0);
        cyc();
        chk("full_winc", {31'b0, winc}, 32'd0);
        chk("full_gnt2", {28'b0, gnt},  32'd0);
        cyc();
        chk("full_winc2", {31'b0, winc}, 32'd0);
        set_in(4'b1000, 1'b0, 1'b0);
        chk("full_release_gnt", {28'b0, gnt}, 32'b1000);
        cyc();
        chk("full_end_busy", {31'b0, busy}, 32'd0);

        // Requester 1 leaves after one word; requester 2 is served next.
        set_in(4'b0110, 1'b0, 1'b0);
        cyc();
        chk("leave_owner", {30'b0, owner}, 32'd1);
        chk("leave_gnt",   {28'b0, gnt},   32'b0010);
        cyc();
        set_in(4'b0100, 1'b0, 1'b0);
        chk("leave_gnt0",  {28'b0, gnt},  32'd0);
        chk("leave_busy",  {31'b0, busy}, 32'd1);
        cyc();
        chk("leave_idle",  {31'b0, busy}, 32'd0);
        cyc();
        chk("next_owner",  {30'b0, owner}, 32'd2);
        chk("next_gnt",    {28'b0, gnt},   32'b0100);
        cyc();
        cyc();
        chk("pre_rst_winc", {31'b0, winc}, 32'd1);

        // Asynchronous reset mid-burst clears outputs at once.
        wrst = 1'b1;
        #1;
        chk("arst_winc",  {31'b0, winc},  32'd0);
        chk("arst_gnt",   {28'b0, gnt},   32'd0);
        chk("arst_busy",  {31'b0, busy},  32'd0);
        chk("arst_wdata", {24'b0, wdata}, 32'd0);
        m_winc  = 1'b0;
        m_wdata = 8'h00;
        @(posedge wclk);
        #1;
        set_in(4'b0101, 1'b0, 1'b0);
        wrst = 1'b0;
        #1;
        chk("post_rst_gnt", {28'b0, gnt}, 32'd0);
        cyc();
        // Reset restores last_owner to NREQ-1, so requester 0 wins over 2.
        chk("post_rst_owner", {30'b0, owner}, 32'd0);
        chk("post_rst_gnt1",  {28'b0, gnt},   32'b0001);
        set_in(4'b0000, 1'b0, 1'b0);
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
